// File: rtl/xdn_bus_pkg.sv
// Shared definitions for XDN bus masters: bus defaults, DMA state encoding
// and the FSM-to-datapath control payload.
package xdn_bus_pkg;

  localparam int unsigned XDN_DATA_WIDTH = 8;
  localparam int unsigned XDN_RAM_LENGTH = 256;

  localparam int unsigned DMA_STATE_W = 3;
  localparam logic [2:0] DMA_IDLE  = 3'd0;
  localparam logic [2:0] DMA_REQ   = 3'd1;
  localparam logic [2:0] DMA_FETCH = 3'd2;
  localparam logic [2:0] DMA_STORE = 3'd3;
  localparam logic [2:0] DMA_DONE  = 3'd4;

  // One-cycle datapath commands issued by the DMA sequencer.
  typedef struct packed {
    logic load;     // latch base addresses and length
    logic capture;  // sample BUS into the data register
    logic step;     // advance both pointers, decrement the count
    logic drive;    // put the data register onto BUS
  } dma_ctl_t;

endpackage

// File: rtl/bus_dma_if.sv
// Control/status link between the DMA sequencer (master) and its datapath (slave).
interface bus_dma_if #(
  parameter int unsigned DW = xdn_bus_pkg::XDN_DATA_WIDTH
);
  import xdn_bus_pkg::*;

  dma_ctl_t        ctl;
  logic [DW-1:0]   src;
  logic [DW-1:0]   dst;
  logic [DW-1:0]   len;
  logic [DW-1:0]   src_ptr;
  logic [DW-1:0]   dst_ptr;
  logic [DW-1:0]   count;

  modport master (output ctl, src, dst, len, input src_ptr, dst_ptr, count);
  modport slave  (input ctl, src, dst, len, output src_ptr, dst_ptr, count);

endinterface

// File: rtl/bus_dma_datapath.sv
// DMA datapath: source/destination pointers, remaining count, data register
// and the tri-state BUS driver.
module bus_dma_datapath import xdn_bus_pkg::*; #(
  parameter int unsigned DATA_WIDTH = XDN_DATA_WIDTH,
  parameter int unsigned RAM_LENGTH = XDN_RAM_LENGTH
) (
  input  logic                  i_CLOCK,
  input  logic                  i_RESET,
  bus_dma_if.slave              ctl_if,
  inout  wire  [DATA_WIDTH-1:0] BUS
);

  localparam logic [DATA_WIDTH-1:0] LAST_ADDR = DATA_WIDTH'(RAM_LENGTH - 1);

  logic [DATA_WIDTH-1:0] r_src;
  logic [DATA_WIDTH-1:0] r_dst;
  logic [DATA_WIDTH-1:0] r_count;
  logic [DATA_WIDTH-1:0] r_data;
  logic [DATA_WIDTH-1:0] w_src_inc;
  logic [DATA_WIDTH-1:0] w_dst_inc;

  // Pointers wrap to 0 after the last RAM word.
  assign w_src_inc = (r_src == LAST_ADDR) ? '0 : r_src + DATA_WIDTH'(1);
  assign w_dst_inc = (r_dst == LAST_ADDR) ? '0 : r_dst + DATA_WIDTH'(1);

  always_ff @(posedge i_CLOCK) begin
    if (i_RESET) begin
      r_src   <= '0;
      r_dst   <= '0;
      r_count <= '0;
      r_data  <= '0;
    end else begin
      if (ctl_if.ctl.load) begin
        r_src   <= ctl_if.src;
        r_dst   <= ctl_if.dst;
        r_count <= ctl_if.len;
      end
      if (ctl_if.ctl.capture) begin
        r_data <= BUS;
      end
      if (ctl_if.ctl.step) begin
        r_src   <= w_src_inc;
        r_dst   <= w_dst_inc;
        r_count <= r_count - DATA_WIDTH'(1);
      end
    end
  end

  assign BUS = ctl_if.ctl.drive ? r_data : 'z;

  assign ctl_if.src_ptr = r_src;
  assign ctl_if.dst_ptr = r_dst;
  assign ctl_if.count   = r_count;

endmodule

// File: rtl/bus_dma.sv
// Bus-mastering DMA: copies LENGTH bytes forward from SRC to DST over the
// shared tri-state BUS, one FETCH/STORE pair per byte, stalling while ungranted.
module bus_dma import xdn_bus_pkg::*; #(
  parameter int unsigned DATA_WIDTH = XDN_DATA_WIDTH,
  parameter int unsigned RAM_LENGTH = XDN_RAM_LENGTH
) (
  input  logic                  i_CLOCK,
  input  logic                  i_RESET,
  inout  wire  [DATA_WIDTH-1:0] BUS,
  input  logic                  i_START,
  input  logic [DATA_WIDTH-1:0] i_SRC,
  input  logic [DATA_WIDTH-1:0] i_DST,
  input  logic [DATA_WIDTH-1:0] i_LENGTH,
  input  logic                  i_GRANT,
  output logic                  o_REQ,
  output logic [DATA_WIDTH-1:0] o_MAR_DATA,
  output logic                  o_RAM_WRITE_BUS,
  output logic                  o_RAM_READ_BUS,
  output logic                  o_BUSY,
  output logic                  o_DONE,
  output logic [DATA_WIDTH-1:0] o_COUNT
);

  logic [DMA_STATE_W-1:0] r_state;
  logic [DMA_STATE_W-1:0] w_state_nxt;
  dma_ctl_t               w_ctl;
  logic [DATA_WIDTH-1:0]  w_mar;
  logic                   w_ram_wr;
  logic                   w_ram_rd;
  logic                   w_run;

  bus_dma_if #(.DW(DATA_WIDTH)) u_ctl_if ();

  assign w_run = ~i_RESET;

  always_ff @(posedge i_CLOCK) begin
    if (i_RESET) begin
      r_state <= DMA_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Bus strobes and datapath commands follow i_GRANT combinationally so a
  // withdrawn grant releases the bus in the same cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_ctl       = '0;
    w_mar       = '0;
    w_ram_wr    = 1'b0;
    w_ram_rd    = 1'b0;
    case (r_state)
      DMA_IDLE: begin
        if (i_START) begin
          if (i_LENGTH != '0) begin
            w_ctl.load  = 1'b1;
            w_state_nxt = DMA_REQ;
          end else begin
            w_state_nxt = DMA_DONE;
          end
        end
      end
      DMA_REQ: begin
        if (i_GRANT) begin
          w_state_nxt = DMA_FETCH;
        end
      end
      DMA_FETCH: begin
        if (i_GRANT) begin
          w_mar         = u_ctl_if.src_ptr;
          w_ram_wr      = 1'b1;
          w_ctl.capture = 1'b1;
          w_state_nxt   = DMA_STORE;
        end
      end
      DMA_STORE: begin
        if (i_GRANT) begin
          w_mar       = u_ctl_if.dst_ptr;
          w_ram_rd    = 1'b1;
          w_ctl.drive = 1'b1;
          w_ctl.step  = 1'b1;
          w_state_nxt = (u_ctl_if.count == DATA_WIDTH'(1)) ? DMA_DONE : DMA_FETCH;
        end
      end
      DMA_DONE: begin
        w_state_nxt = DMA_IDLE;
      end
      default: begin
        w_state_nxt = DMA_IDLE;
      end
    endcase
    // Reset silences the bus before the state register has been cleared.
    if (!w_run) begin
      w_ctl    = '0;
      w_mar    = '0;
      w_ram_wr = 1'b0;
      w_ram_rd = 1'b0;
    end
  end

  assign u_ctl_if.ctl = w_ctl;
  assign u_ctl_if.src = i_SRC;
  assign u_ctl_if.dst = i_DST;
  assign u_ctl_if.len = i_LENGTH;

  bus_dma_datapath #(
    .DATA_WIDTH (DATA_WIDTH),
    .RAM_LENGTH (RAM_LENGTH)
  ) u_datapath (
    .i_CLOCK (i_CLOCK),
    .i_RESET (i_RESET),
    .ctl_if  (u_ctl_if.slave),
    .BUS     (BUS)
  );

  assign o_REQ           = w_run & ((r_state == DMA_REQ) || (r_state == DMA_FETCH) ||
                                    (r_state == DMA_STORE));
  assign o_BUSY          = w_run & (r_state != DMA_IDLE);
  assign o_DONE          = w_run & (r_state == DMA_DONE);
  assign o_COUNT         = w_run ? u_ctl_if.count : '0;
  assign o_MAR_DATA      = w_mar;
  assign o_RAM_WRITE_BUS = w_ram_wr;
  assign o_RAM_READ_BUS  = w_ram_rd;

endmodule

// File: tb/tb_bus_dma.sv
// Bench for bus_dma: RAM model on a shared BUS, forward-copy reference model,
// queue-based scoreboard checked by an independent monitor.
module tb_bus_dma;

  localparam int unsigned DW = 8;
  localparam int unsigned RL = 256;

  typedef struct packed {
    logic [DW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic          grant;
  logic [DW-1:0] src;
  logic [DW-1:0] dst;
  logic [DW-1:0] len;
  wire  [DW-1:0] BUS;
  logic          req;
  logic          ram_wr;
  logic          ram_rd;
  logic          busy;
  logic          done;
  logic [DW-1:0] mar;
  logic [DW-1:0] count;

  logic [DW-1:0] mem    [RL];
  logic [DW-1:0] shadow [RL];
  logic          fill_en;
  logic [DW-1:0] fill_a;
  logic [DW-1:0] fill_d;

  int cyc             = 0;
  int n_checks        = 0;
  int n_errors        = 0;
  int n_done          = 0;
  int n_req_cycles    = 0;
  int n_strobe_cycles = 0;

  wr_t           exp_wr   [$];
  logic [DW-1:0] exp_rd   [$];
  int            exp_done [$];
  wr_t           mon_e;

  bus_dma #(.DATA_WIDTH(DW), .RAM_LENGTH(RL)) dut (
    .i_CLOCK         (clk),
    .i_RESET         (rst),
    .BUS             (BUS),
    .i_START         (start),
    .i_SRC           (src),
    .i_DST           (dst),
    .i_LENGTH        (len),
    .i_GRANT         (grant),
    .o_REQ           (req),
    .o_MAR_DATA      (mar),
    .o_RAM_WRITE_BUS (ram_wr),
    .o_RAM_READ_BUS  (ram_rd),
    .o_BUSY          (busy),
    .o_DONE          (done),
    .o_COUNT         (count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM drives on its write-bus strobe; a keeper holds the released bus at 0.
  assign BUS = ram_wr ? mem[mar] : 'z;
  assign BUS = (ram_wr || ram_rd) ? 'z : '0;

  always @(posedge clk) begin
    if (fill_en) mem[fill_a] <= fill_d;
    else if (ram_rd) mem[mar] <= BUS;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Forward byte-by-byte copy of n bytes with modulo addressing.
  task automatic model_copy(input logic [DW-1:0] s, input logic [DW-1:0] d, input int n);
    logic [DW-1:0] sa;
    logic [DW-1:0] da;
    for (int i = 0; i < n; i++) begin
      sa = DW'((int'(s) + i) % int'(RL));
      da = DW'((int'(d) + i) % int'(RL));
      shadow[da] = shadow[sa];
      exp_rd.push_back(sa);
      exp_wr.push_back(wr_t'({da, shadow[da]}));
    end
  endtask

  task automatic check_ram(input string name);
    int bad;
    bad = 0;
    for (int a = 0; a < int'(RL); a++) if (mem[a] !== shadow[a]) bad++;
    check(name, 32'(bad), 32'(0));
  endtask

  // Monitor: invariants every cycle, scoreboard pops on strobes and o_DONE.
  always @(negedge clk) begin
    if (req) n_req_cycles++;
    if (ram_wr || ram_rd) n_strobe_cycles++;
    check("strobe_exclusive", 32'(ram_wr & ram_rd), 32'(0));
    if (!ram_wr && !ram_rd) begin
      check("bus_released", 32'(BUS), 32'(0));
      check("mar_idle", 32'(mar), 32'(0));
    end
    if (!grant) check("strobes_without_grant", 32'({ram_wr, ram_rd}), 32'(0));
    if (rst) check("reset_outputs", 32'({req, ram_wr, ram_rd, busy, done, mar, count}), 32'(0));
    if (ram_wr) begin
      check("fetch_expected", 32'(exp_rd.size() != 0), 32'(1));
      if (exp_rd.size() != 0) check("fetch_addr", 32'(mar), 32'(exp_rd.pop_front()));
    end
    if (ram_rd) begin
      check("store_expected", 32'(exp_wr.size() != 0), 32'(1));
      if (exp_wr.size() != 0) begin
        mon_e = exp_wr.pop_front();
        check("store_addr", 32'(mar), 32'(mon_e.addr));
        check("store_data", 32'(BUS), 32'(mon_e.data));
      end
    end
    if (done) begin
      n_done++;
      check("done_expected", 32'(exp_done.size() != 0), 32'(1));
      if (exp_done.size() != 0) check("done_cycle", 32'(cyc), 32'(exp_done.pop_front()));
    end
  end

  // mode 0: grant held; 1: grant low for 5 cycles from drop_at; 2: random grant.
  // restart_at != 0 re-asserts i_START (LEN=5) in that cycle after the start.
  task automatic run_copy(input logic [DW-1:0] s, input logic [DW-1:0] d,
                          input logic [DW-1:0] l, input int mode,
                          input int drop_at, input int restart_at);
    bit gpat[$];
    bit g;
    int need, highs, k, c0, base_done, base_req, base_strobe;
    need  = 2 * int'(l) + 1;
    highs = 0;
    k     = 0;
    // REQ, each FETCH and each STORE advance on one granted cycle.
    while (l != '0 && highs < need) begin
      k++;
      case (mode)
        1:       g = !(k >= drop_at && k < drop_at + 5);
        2:       g = ($urandom_range(3) != 0);
        default: g = 1'b1;
      endcase
      gpat.push_back(g);
      if (g) highs++;
    end
    base_done   = n_done;
    base_req    = n_req_cycles;
    base_strobe = n_strobe_cycles;
    src = s; dst = d; len = l; start = 1'b1; c0 = cyc;
    exp_done.push_back((l == '0) ? c0 + 1 : c0 + k + 1);
    model_copy(s, d, int'(l));
    tick();
    start = 1'b0;
    src = DW'($urandom); dst = DW'($urandom); len = DW'($urandom);
    foreach (gpat[i]) begin
      grant = gpat[i];
      start = (restart_at != 0) && (i + 1 == restart_at);
      if (start) begin
        src = DW'($urandom); dst = DW'($urandom); len = DW'(5);
      end
      tick();
    end
    start = 1'b0;
    grant = 1'b1;
    for (int t = 0; t < 64 && n_done == base_done; t++) tick();
    repeat (3) tick();
    check("done_once", 32'(n_done - base_done), 32'(1));
    check("fetches_drained", 32'(exp_rd.size()), 32'(0));
    check("stores_drained", 32'(exp_wr.size()), 32'(0));
    check("idle_after_done", 32'({busy, req}), 32'(0));
    check_ram("ram_contents");
    if (l == '0) begin
      check("len0_req_cycles", 32'(n_req_cycles - base_req), 32'(0));
      check("len0_strobe_cycles", 32'(n_strobe_cycles - base_strobe), 32'(0));
    end
  endtask

  // LEN=8 aborted by reset during the third FETCH (cycle 6 after start).
  task automatic run_reset();
    int base_done;
    base_done = n_done;
    src = 8'h05; dst = 8'hC0; len = 8'd8; start = 1'b1; grant = 1'b1;
    model_copy(8'h05, 8'hC0, 2);
    tick();
    start = 1'b0;
    repeat (5) tick();
    check("abort_in_fetch", 32'({req, count}), 32'({1'b1, 8'd6}));
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    #1;
    check("abort_idle", 32'({busy, req, count}), 32'(0));
    repeat (6) tick();
    check("abort_no_done", 32'(n_done - base_done), 32'(0));
    check("abort_fetches_drained", 32'(exp_rd.size()), 32'(0));
    check("abort_stores_drained", 32'(exp_wr.size()), 32'(0));
    check_ram("abort_ram");
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", n_checks, n_errors);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; grant = 1'b1;
    src = '0; dst = '0; len = '0;
    fill_en = 1'b0; fill_a = '0; fill_d = '0;
    for (int a = 0; a < int'(RL); a++) begin
      fill_en = 1'b1;
      fill_a  = DW'(a);
      fill_d  = DW'($urandom);
      shadow[a] = fill_d;
      tick();
    end
    fill_en = 1'b0;
    tick();
    rst = 1'b0;
    tick();
    check("post_reset_idle", 32'({busy, done, req, count}), 32'(0));

    run_copy(8'h10, 8'h80, 8'd4, 0, 0, 0);
    run_copy(8'h33, 8'h55, 8'd0, 0, 0, 0);
    run_copy(8'hFE, 8'h20, 8'd4, 0, 0, 0);
    run_copy(8'h30, 8'h90, 8'd3, 1, 5, 0);
    run_reset();
    run_copy(8'h07, 8'hD0, 8'd3, 0, 0, 0);
    run_copy(8'h60, 8'hA0, 8'd2, 0, 0, 3);
    run_copy(8'h40, 8'h42, 8'd6, 0, 0, 0);
    for (int r = 0; r < 10; r++) begin
      run_copy(DW'($urandom), DW'($urandom), DW'($urandom_range(12, 1)), 2, 0,
               ($urandom_range(3) == 0) ? 3 : 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
